// File: rtl/stage_operator_mixer.sv
// Operator mixer stage: sums carrier operators per voice, voices per frame.
// Optional STAGE_MIXER_SATURATE_EN: clamp the frame mix instead of wrapping.
module stage_operator_mixer #(
  parameter int NUM_OPERATORS = 8,
  parameter int NUM_VOICES    = 32,
  parameter int OP_BITS       = 3,
  parameter int VOICE_BITS    = 5,
  parameter int MIX_SHIFT     = 5
) (
  input  logic                                i_Clock,
  input  logic                                i_Reset_n,
  input  logic [VOICE_BITS+OP_BITS-1:0]       i_VoiceOperator,
  input  logic [15:0]                         i_AlgorithmWord,
  input  logic signed [15:0]                  i_Waveform,
  output logic                                o_ModWriteEnable,
  output logic [VOICE_BITS+OP_BITS-1:0]       o_ModWriteAddr,
  output logic signed [15:0]                  o_ModWriteData,
  output logic                                o_VoiceValid,
  output logic [VOICE_BITS-1:0]               o_Voice,
  output logic signed [OP_BITS+15:0]          o_VoiceSample,
  output logic                                o_MixValid,
  output logic signed [15:0]                  o_MixSample
);

  localparam int ID_BITS  = VOICE_BITS + OP_BITS;
  localparam int ACC_BITS = OP_BITS + 16;
  localparam int MIX_BITS = VOICE_BITS + OP_BITS + 16;
  localparam logic signed [MIX_BITS-1:0] SAT_MAX = MIX_BITS'(32767);
  localparam logic signed [MIX_BITS-1:0] SAT_MIN = -MIX_BITS'(32768);

  logic [ID_BITS-1:0]         r_Id;
  logic                       r_Carrier;
  logic signed [15:0]         r_Wave;
  logic                       r_ModWe;
  logic signed [ACC_BITS-1:0] r_Acc;
  logic signed [ACC_BITS-1:0] r_VoiceSample;
  logic [VOICE_BITS-1:0]      r_Voice;
  logic                       r_VoiceValid;
  logic signed [MIX_BITS-1:0] r_Mix;
  logic signed [15:0]         r_MixSample;
  logic                       r_MixValid;

  logic [OP_BITS-1:0]         w_Op;
  logic [VOICE_BITS-1:0]      w_VoiceId;
  logic                       w_OpLast;
  logic signed [ACC_BITS-1:0] w_Contrib;
  logic signed [ACC_BITS-1:0] w_AccSum;
  logic signed [MIX_BITS-1:0] w_VoiceExt;
  logic signed [MIX_BITS-1:0] w_MixSum;
  logic signed [MIX_BITS-1:0] w_Shifted;
  logic                       w_VoiceLast;
  logic signed [15:0]         w_Sat16;
  logic                       w_unused_alg;
  logic                       w_unused_hi;

  assign w_unused_alg = |i_AlgorithmWord[15:1];

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Id      <= '0;
      r_Carrier <= 1'b0;
      r_Wave    <= '0;
      r_ModWe   <= 1'b0;
    end else begin
      r_Id      <= i_VoiceOperator;
      r_Carrier <= i_AlgorithmWord[0];
      r_Wave    <= i_Waveform;
      r_ModWe   <= 1'b1;
    end
  end

  assign w_Op      = r_Id[OP_BITS-1:0];
  assign w_VoiceId = r_Id[ID_BITS-1:OP_BITS];
  assign w_OpLast  = (w_Op == OP_BITS'(NUM_OPERATORS - 1));
  assign w_Contrib = r_Carrier ? {{OP_BITS{r_Wave[15]}}, r_Wave} : '0;
  assign w_AccSum  = (w_Op == '0) ? w_Contrib : r_Acc + w_Contrib;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Acc         <= '0;
      r_VoiceSample <= '0;
      r_Voice       <= '0;
      r_VoiceValid  <= 1'b0;
    end else begin
      r_Acc        <= w_AccSum;
      r_VoiceValid <= w_OpLast;
      if (w_OpLast) begin
        r_VoiceSample <= w_AccSum;
        r_Voice       <= w_VoiceId;
      end
    end
  end

  assign w_VoiceExt  = {{VOICE_BITS{r_VoiceSample[ACC_BITS-1]}}, r_VoiceSample};
  assign w_MixSum    = (r_Voice == '0) ? w_VoiceExt : r_Mix + w_VoiceExt;
  assign w_VoiceLast = (r_Voice == VOICE_BITS'(NUM_VOICES - 1));
  assign w_Shifted   = w_MixSum >>> MIX_SHIFT;

`ifdef STAGE_MIXER_SATURATE_EN
  assign w_unused_hi = 1'b0;
  always_comb begin
    w_Sat16 = w_Shifted[15:0];
    if (w_Shifted > SAT_MAX)
      w_Sat16 = 16'sh7fff;
    else if (w_Shifted < SAT_MIN)
      w_Sat16 = -16'sh8000;
  end
`else
  assign w_unused_hi = |{w_Shifted[MIX_BITS-1:16], SAT_MAX, SAT_MIN};
  assign w_Sat16     = w_Shifted[15:0];
`endif

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Mix       <= '0;
      r_MixSample <= '0;
      r_MixValid  <= 1'b0;
    end else begin
      r_MixValid <= r_VoiceValid && w_VoiceLast;
      if (r_VoiceValid)
        r_Mix <= w_MixSum;
      if (r_VoiceValid && w_VoiceLast)
        r_MixSample <= w_Sat16;
    end
  end

  assign o_ModWriteEnable = r_ModWe;
  assign o_ModWriteAddr   = r_Id;
  assign o_ModWriteData   = r_Wave;
  assign o_VoiceValid     = r_VoiceValid;
  assign o_Voice          = r_Voice;
  assign o_VoiceSample    = r_VoiceSample;
  assign o_MixValid       = r_MixValid;
  assign o_MixSample      = r_MixSample;

endmodule

// File: tb/tb_stage_operator_mixer.sv
// Directed bench for stage_operator_mixer.
// Expected mix values depend on STAGE_MIXER_SATURATE_EN.
module tb_stage_operator_mixer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         i_VoiceOperator = '0;
  logic [15:0]        i_AlgorithmWord = '0;
  logic signed [15:0] i_Waveform = '0;
  logic               o_ModWriteEnable;
  logic [7:0]         o_ModWriteAddr;
  logic signed [15:0] o_ModWriteData;
  logic               o_VoiceValid;
  logic [4:0]         o_Voice;
  logic signed [18:0] o_VoiceSample;
  logic               o_MixValid;
  logic signed [15:0] o_MixSample;

  stage_operator_mixer dut (
    .i_Clock          (clk),
    .i_Reset_n        (rst_n),
    .i_VoiceOperator  (i_VoiceOperator),
    .i_AlgorithmWord  (i_AlgorithmWord),
    .i_Waveform       (i_Waveform),
    .o_ModWriteEnable (o_ModWriteEnable),
    .o_ModWriteAddr   (o_ModWriteAddr),
    .o_ModWriteData   (o_ModWriteData),
    .o_VoiceValid     (o_VoiceValid),
    .o_Voice          (o_Voice),
    .o_VoiceSample    (o_VoiceSample),
    .o_MixValid       (o_MixValid),
    .o_MixSample      (o_MixSample)
  );

  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;
  int mix_cnt = 0;
  int voice_cnt = 0;
  int mw_bad = 0;
  logic any_nz = 1'b0;
  logic signed [18:0] vsamp [32];
  logic signed [15:0] mix_last;
  logic signed [15:0] fw [256];
  logic               fc [256];
  logic [7:0]         mw2_addr;
  logic signed [15:0] mw2_data;

  always @(negedge clk) begin
    if (o_VoiceValid) begin
      vsamp[o_Voice] = o_VoiceSample;
      voice_cnt++;
    end
    if (o_MixValid) begin
      mix_last = o_MixSample;
      mix_cnt++;
    end
    if (o_VoiceSample != 0 || o_MixSample != 0 || o_ModWriteData != 0)
      any_nz = 1'b1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int id, input logic car,
                      input logic signed [15:0] wv);
    logic [15:0] junk;
    junk = 16'($urandom);
    i_VoiceOperator = id[7:0];
    i_AlgorithmWord = {junk[15:1], car};
    i_Waveform      = wv;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    for (int v = 0; v < 32; v++) vsamp[v] = 'x;
    mix_cnt   = 0;
    voice_cnt = 0;
    mw_bad    = 0;
    mix_last  = 'x;
  endtask

  task automatic run_frame();
    clear_obs();
    for (int id = 0; id < 256; id++) begin
      step(id, fc[id], fw[id]);
      if (o_ModWriteEnable !== 1'b1 || o_ModWriteAddr !== 8'(id) ||
          o_ModWriteData !== fw[id])
        mw_bad++;
      if (id == 2) begin
        mw2_addr = o_ModWriteAddr;
        mw2_data = o_ModWriteData;
      end
    end
  endtask

  task automatic pads();
    for (int p = 0; p < 4; p++) step(p, 1'b0, 16'sd0);
  endtask

  task automatic fill(input logic c, input logic signed [15:0] w);
    for (int k = 0; k < 256; k++) begin
      fc[k] = c;
      fw[k] = w;
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_modwe", o_ModWriteEnable, 0);
    chk("rst_voicevalid", o_VoiceValid, 0);
    chk("rst_mixvalid", o_MixValid, 0);
    chk("rst_voicesample", o_VoiceSample, 0);
    chk("rst_mixsample", o_MixSample, 0);
    rst_n = 1'b1;

    // all-zero frame with mix latency check
    fill(1'b1, 16'sd0);
    any_nz = 1'b0;
    run_frame();
    chk("zero_modwrite", mw_bad, 0);
    step(0, 1'b0, 16'sd0);
    chk("zero_voicevalid_lat2", o_VoiceValid, 1);
    chk("zero_voice_idx", o_Voice, 31);
    chk("zero_mixvalid_early", o_MixValid, 0);
    step(1, 1'b0, 16'sd0);
    chk("zero_mixvalid_lat3", o_MixValid, 1);
    chk("zero_mixsample", o_MixSample, 0);
    step(2, 1'b0, 16'sd0);
    chk("zero_mixvalid_pulse", o_MixValid, 0);
    chk("zero_mix_count", mix_cnt, 1);
    chk("zero_voice_count", voice_cnt, 32);
    chk("zero_any_nonzero", any_nz, 0);

    // voice 3 op 0 only
    fill(1'b0, 16'sd0);
    fc[24] = 1'b1;
    fw[24] = 16'sd32767;
    run_frame();
    pads();
    chk("v3_voice3", vsamp[3], 32767);
    chk("v3_voice4", vsamp[4], 0);
    chk("v3_mix", mix_last, 1023);

    // voice 0 carriers plus a non-carrier
    fill(1'b0, 16'sd0);
    fc[0] = 1'b1; fw[0] = 16'sd1000;
    fc[1] = 1'b1; fw[1] = -16'sd300;
    fc[2] = 1'b0; fw[2] = 16'sd5000;
    run_frame();
    pads();
    chk("v0_voice0", vsamp[0], 700);
    chk("v0_mw_addr", mw2_addr, 2);
    chk("v0_mw_data", mw2_data, 5000);
    chk("v0_modwrite_all", mw_bad, 0);
    chk("v0_mix", mix_last, 21);

    // full-scale positive
    fill(1'b1, 16'sd32767);
    run_frame();
    pads();
    chk("pos_voice31", vsamp[31], 262136);
    chk("pos_voice0", vsamp[0], 262136);
`ifdef STAGE_MIXER_SATURATE_EN
    chk("pos_mix", mix_last, 32767);
`else
    chk("pos_mix", mix_last, -8);
`endif

    // full-scale negative
    fill(1'b1, -16'sd32768);
    run_frame();
    pads();
    chk("neg_voice7", vsamp[7], -262144);
`ifdef STAGE_MIXER_SATURATE_EN
    chk("neg_mix", mix_last, -32768);
`else
    chk("neg_mix", mix_last, 0);
`endif

    // reset mid-frame at ID 100, resume at ID 104
    fill(1'b1, 16'sd64);
    clear_obs();
    for (int id = 0; id < 100; id++) step(id, 1'b1, 16'sd64);
    rst_n = 1'b0;
    for (int id = 100; id < 103; id++) begin
      step(id, 1'b1, 16'sd64);
      chk("mrst_modwe", o_ModWriteEnable, 0);
      chk("mrst_voicesample", o_VoiceSample, 0);
      chk("mrst_mixsample", o_MixSample, 0);
    end
    rst_n = 1'b1;
    for (int id = 104; id < 256; id++) step(id, 1'b1, 16'sd64);
    pads();
    chk("mrst_voice13", vsamp[13], 512);
    chk("mrst_mix_count", mix_cnt, 1);
    chk("mrst_partial_mix", mix_last, 304);

    run_frame();
    pads();
    chk("post_voice12", vsamp[12], 512);
    chk("post_mix", mix_last, 512);
    chk("post_mix_count", mix_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
